// File: rtl/timer_pkg.sv
// timer_pkg: shared types and defaults for the timer's input-conditioning blocks
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } debounce_state_t;
  localparam int CLK_FREQ_HZ             = 100_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int SYNC_STAGES_DEFAULT     = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: plain flop chain bringing an asynchronous level into the CLK domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);
  logic [STAGES-1:0] q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) q <= '0;
    else q <= {q[STAGES-2:0], D};
  assign Q = q[STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncing button and accepts a level only after it is stable
module button_debouncer
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic IN,
  output logic OUT
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s;
  logic out_nx;
  logic [CW-1:0] cnt, cnt_nx;
  debounce_state_t state, state_nx;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .D    (IN),
    .Q    (s)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      OUT   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      OUT   <= out_nx;
    end
  // a reversal of s in a WAIT state drops back to the current level's IDLE with cnt cleared
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    out_nx   = OUT;
    case (state)
      IDLE_LOW:  if (s) begin state_nx = WAIT_HIGH; cnt_nx = CW'(1); end
      WAIT_HIGH: if (!s) state_nx = IDLE_LOW;
                 else if (cnt == LAST) begin state_nx = IDLE_HIGH; out_nx = 1'b1; end
                 else cnt_nx = cnt + CW'(1);
      IDLE_HIGH: if (!s) begin state_nx = WAIT_LOW; cnt_nx = CW'(1); end
      WAIT_LOW:  if (s) state_nx = IDLE_HIGH;
                 else if (cnt == LAST) begin state_nx = IDLE_LOW; out_nx = 1'b0; end
                 else cnt_nx = cnt + CW'(1);
      default:   state_nx = IDLE_LOW;
    endcase
  end
endmodule
